// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM state encoding and shared instruction constants.
package fetch_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;
  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: word-addressed combinational instruction memory port.
interface instr_fetch_unit_if #(parameter int DW = 32);
  logic [DW-1:0] im_addr;
  logic [DW-1:0] im_instr;
  modport master (output im_addr, input im_instr);
  modport slave (input im_addr, output im_instr);
endinterface

// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: stage register holding {instr, pc, pc_next, valid} with load/hold/flush.
module ifid_pipe_reg import fetch_pkg::*; #(
  parameter int DW = 32,
  parameter logic [DW-1:0] NOP_INSTR = DW'(NOP_INSTR_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          flush,
  input  logic [DW-1:0] instr_in,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] pc_next_in,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] pc_next,
  output logic          valid
);
  logic [DW-1:0] instr_q, instr_d, pc_q, pc_d, pc_next_q, pc_next_d;
  logic valid_q, valid_d;
  logic take;
  always_comb begin
    take      = load && !flush;
    instr_d   = flush ? NOP_INSTR : take ? instr_in : instr_q;
    pc_d      = take ? pc_in : pc_q;
    pc_next_d = take ? pc_next_in : pc_next_q;
    valid_d   = flush ? 1'b0 : take ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end
  assign instr   = instr_q;
  assign pc      = pc_q;
  assign pc_next = pc_next_q;
  assign valid   = valid_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, fetch FSM and IF/ID capture with stall, redirect and halt.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int DW = 32,
  parameter logic [DW-1:0] RESET_PC = '0,
  parameter int unsigned PC_INC = 1,
  parameter logic [DW-1:0] NOP_INSTR = DW'(NOP_INSTR_DEF),
  parameter logic [DW-1:0] HALT_INSTR = DW'(HALT_INSTR_DEF),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [DW-1:0] redirect_pc,
  instr_fetch_unit_if.master im,
  output logic [DW-1:0] ifid_instr,
  output logic [DW-1:0] ifid_pc,
  output logic [DW-1:0] ifid_pc_next,
  output logic          ifid_valid,
  output logic          halted,
  output logic [CW-1:0] fetch_count
);
  fetch_state_e state_q, state_d;
  logic [DW-1:0] pc_q, pc_d, pc_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run, redir, load, flush, is_halt;
  assign pc_inc = pc_q + DW'(PC_INC);
  always_comb begin
    run     = state_q == S_RUN;
    redir   = run && redirect_valid;
    load    = run && !redirect_valid && !stall;
    is_halt = im.im_instr == HALT_INSTR;
    // halt's own capture is shown for one unstalled cycle, then flushed for good
    flush   = redir || (state_q == S_HALT && !stall);
    pc_d    = redir ? redirect_pc : (load && !is_halt) ? pc_inc : pc_q;
    cnt_d   = (load && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    state_d = (state_q == S_IDLE && start) ? S_RUN : (load && is_halt) ? S_HALT : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  ifid_pipe_reg #(.DW(DW), .NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .flush      (flush),
    .instr_in   (im.im_instr),
    .pc_in      (pc_q),
    .pc_next_in (pc_inc),
    .instr      (ifid_instr),
    .pc         (ifid_pc),
    .pc_next    (ifid_pc_next),
    .valid      (ifid_valid)
  );
  assign im.im_addr  = pc_q;
  assign halted      = state_q == S_HALT;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plan plus randomized traffic against a behavioural fetch model.
module tb_instr_fetch_unit;
  localparam int CW = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_next;
  logic ifid_valid, halted;
  logic [CW-1:0] fetch_count;
  logic halt_en = 1'b0;
  logic [31:0] halt_addr = '0;
  int n_chk = 0, n_err = 0;

  int m_state;
  logic [31:0] m_pc, m_instr, m_ipc, m_inext;
  logic m_valid;
  int m_cnt;

  instr_fetch_unit_if #(.DW(32)) im ();

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic en, input logic [31:0] ha);
    if (en && a == ha) return HALT;
    if (a < 3) return 32'h11 * (a + 1);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  assign im.im_instr = mem_rd(im.im_addr, halt_en, halt_addr);

  instr_fetch_unit #(.CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im             (im),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_next   (ifid_pc_next),
    .ifid_valid     (ifid_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".im_addr"}, 64'(im.im_addr), 64'(m_pc));
    chk({tag, ".instr"}, 64'(ifid_instr), 64'(m_instr));
    chk({tag, ".pc"}, 64'(ifid_pc), 64'(m_ipc));
    chk({tag, ".pc_next"}, 64'(ifid_pc_next), 64'(m_inext));
    chk({tag, ".valid"}, 64'(ifid_valid), 64'(m_valid));
    chk({tag, ".halted"}, 64'(halted), 64'(m_state == 2));
    chk({tag, ".count"}, 64'(fetch_count), 64'(m_cnt));
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_instr = NOP; m_ipc = '0; m_inext = '0; m_valid = 1'b0; m_cnt = 0;
  endtask

  // asynchronous reset: asserted between edges and checked before any edge arrives
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic s_start, input logic s_stall,
                     input logic s_rv, input logic [31:0] s_rpc);
    logic [31:0] f;
    int ns;
    logic [31:0] npc, ninstr, nipc, ninext;
    logic nvalid;
    int ncnt;
    start = s_start; stall = s_stall; redirect_valid = s_rv; redirect_pc = s_rpc;
    f = mem_rd(m_pc, halt_en, halt_addr);
    ns = m_state; npc = m_pc; ninstr = m_instr; nipc = m_ipc; ninext = m_inext;
    nvalid = m_valid; ncnt = m_cnt;
    if (m_state == 0) begin
      if (s_start) ns = 1;
    end else if (m_state == 1) begin
      if (s_rv) begin
        npc = s_rpc; ninstr = NOP; nvalid = 1'b0;
      end else if (!s_stall) begin
        ninstr = f; nipc = m_pc; ninext = m_pc + 32'd1; nvalid = 1'b1;
        ncnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (f == HALT) ns = 2;
        else npc = m_pc + 32'd1;
      end
    end else if (!s_stall) begin
      ninstr = NOP; nvalid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_state = ns; m_pc = npc; m_instr = ninstr; m_ipc = nipc; m_inext = ninext;
    m_valid = nvalid; m_cnt = ncnt;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12 check_all("reset");
    rst = 1'b0;
    cyc("idle_stall", 0, 1, 1, 32'h99);
    cyc("start", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("run", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("stall", 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc("unstall", 0, 0, 0, 0);
    cyc("redir_stall", 0, 1, 1, 32'h40);
    for (int i = 0; i < 3; i++) cyc("post_redir", 1, 0, 0, 0);
    halt_en = 1'b1; halt_addr = 32'h44;
    cyc("pre_wrong_halt", 0, 0, 0, 0);
    cyc("wrong_halt", 0, 0, 1, 32'h100);
    cyc("redir_top", 0, 0, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) cyc("wrap", 0, 0, 0, 0);
    do_reset("async_rst");
    halt_addr = 32'h3;
    cyc("h_start", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("h_run", 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("h_stall", 0, 1, 0, 0);
    cyc("h_drain", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("h_poke", 1, i[0], 1, 32'h20);
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0) begin
        halt_en = ($urandom % 2) == 1;
        halt_addr = $urandom % 64;
        do_reset("rnd_rst");
      end
      cyc("rnd", ($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
          ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom % 64);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
